// File: rtl/matrix_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_bank: multi-slot matrix store. Matrices are written and read back   |
// | as handshaked row-major element streams.                                   |
// | The optional column-major readout is enabled by MATRIX_BANK_TRANSPOSE_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matrix_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_ROWS   = 5,
   parameter int MAX_COLS   = 5,
   parameter int NUM_SLOTS  = 8,
   localparam int ROW_W  = $clog2(MAX_ROWS + 1),
   localparam int COL_W  = $clog2(MAX_COLS + 1),
   localparam int SLOT_W = $clog2(NUM_SLOTS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_start,
   input  logic [SLOT_W-1:0]            wr_slot,
   input  logic [ROW_W-1:0]             wr_rows,
   input  logic [COL_W-1:0]             wr_cols,
   input  logic                         wr_valid,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   output logic                         wr_ready,
   output logic                         wr_done,
   input  logic                         rd_start,
   input  logic [SLOT_W-1:0]            rd_slot,
   input  logic                         rd_transpose,
   output logic [ROW_W-1:0]             rd_rows,
   output logic [COL_W-1:0]             rd_cols,
   output logic                         rd_valid,
   output logic signed [DATA_WIDTH-1:0] rd_data,
   output logic                         rd_last,
   input  logic                         rd_ready,
   output logic [NUM_SLOTS-1:0]         slot_valid,
   output logic                         err
);
   localparam int DIM_W   = (ROW_W > COL_W) ? ROW_W : COL_W;
   localparam int SLOT_SZ = MAX_ROWS * MAX_COLS;
   localparam int DEPTH   = NUM_SLOTS * SLOT_SZ;
   localparam int ADDR_W  = $clog2(DEPTH);

   typedef enum logic {W_IDLE, W_FILL}   wstate_t;
   typedef enum logic {R_IDLE, R_STREAM} rstate_t;

   logic signed [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ROW_W-1:0]             dim_rows [NUM_SLOTS];
   logic [COL_W-1:0]             dim_cols [NUM_SLOTS];

   wstate_t             wstate;
   logic [SLOT_W-1:0]   wslot;
   logic [ROW_W-1:0]    wrows, wr_r;
   logic [COL_W-1:0]    wcols, wr_c;

   rstate_t             rstate;
   logic [SLOT_W-1:0]   rslot;
   logic                rtr;
   logic [DIM_W-1:0]    rd_i, rd_j, out_n, in_n;

   // Every element lives at a fixed stride of MAX_COLS regardless of actual dims
   function automatic logic [ADDR_W-1:0] addr_of(input logic [SLOT_W-1:0] s,
                                                 input logic [DIM_W-1:0]  r,
                                                 input logic [DIM_W-1:0]  c);
      return ADDR_W'(int'(s) * SLOT_SZ + int'(r) * MAX_COLS + int'(c));
   endfunction

   logic tr_sel;
`ifdef MATRIX_BANK_TRANSPOSE_EN
   assign tr_sel = rd_transpose;
`else
   logic unused_transpose;
   assign tr_sel           = 1'b0;
   assign unused_transpose = rd_transpose;
`endif

   logic wr_cmd_ok, wr_accept, wr_reject, wr_hs, wr_last_hs;
   logic rd_slot_ok, rd_blocked, rd_accept, rd_reject;

   assign wr_cmd_ok = (wr_rows != '0) && (wr_rows <= ROW_W'(MAX_ROWS)) &&
                      (wr_cols != '0) && (wr_cols <= COL_W'(MAX_COLS)) &&
                      ({1'b0, wr_slot} < (SLOT_W+1)'(NUM_SLOTS));
   assign wr_accept  = (wstate == W_IDLE) && wr_start && wr_cmd_ok;
   assign wr_reject  = wr_start && !wr_accept;
   assign wr_hs      = wr_valid && wr_ready;
   assign wr_last_hs = wr_hs && (wr_r == wrows - 1'b1) && (wr_c == wcols - 1'b1);

   // A slot being (or about to be) written is hidden from readers; write wins ties
   assign rd_slot_ok = ({1'b0, rd_slot} < (SLOT_W+1)'(NUM_SLOTS));
   assign rd_blocked = ((wstate == W_FILL) && (rd_slot == wslot)) ||
                       (wr_accept && (rd_slot == wr_slot));
   assign rd_accept  = (rstate == R_IDLE) && rd_start && rd_slot_ok &&
                       slot_valid[rd_slot] && !rd_blocked;
   assign rd_reject  = rd_start && !rd_accept;

   logic [DIM_W-1:0]  st_rows, st_cols, out0, in0, nxt_i, nxt_j;
   logic [ADDR_W-1:0] nxt_addr;

   always_comb begin
      st_rows  = DIM_W'(dim_rows[rd_slot]);
      st_cols  = DIM_W'(dim_cols[rd_slot]);
      out0     = tr_sel ? st_cols : st_rows;
      in0      = tr_sel ? st_rows : st_cols;
      nxt_j    = (rd_j == in_n - 1'b1) ? '0 : rd_j + 1'b1;
      nxt_i    = (rd_j == in_n - 1'b1) ? rd_i + 1'b1 : rd_i;
      nxt_addr = rtr ? addr_of(rslot, nxt_j, nxt_i) : addr_of(rslot, nxt_i, nxt_j);
   end

   // Storage and dimension tables are intentionally left out of reset
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         dim_rows[wr_slot] <= wr_rows;
         dim_cols[wr_slot] <= wr_cols;
      end
      if (wr_hs)
         mem[addr_of(wslot, DIM_W'(wr_r), DIM_W'(wr_c))] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate     <= W_IDLE;
         wslot      <= '0;
         wrows      <= '0;
         wcols      <= '0;
         wr_r       <= '0;
         wr_c       <= '0;
         wr_ready   <= 1'b0;
         wr_done    <= 1'b0;
         slot_valid <= '0;
      end else begin
         wr_done <= 1'b0;
         case (wstate)
            W_IDLE: if (wr_accept) begin
               wslot               <= wr_slot;
               wrows               <= wr_rows;
               wcols               <= wr_cols;
               wr_r                <= '0;
               wr_c                <= '0;
               slot_valid[wr_slot] <= 1'b0;
               wr_ready            <= 1'b1;
               wstate              <= W_FILL;
            end
            W_FILL: if (wr_hs) begin
               if (wr_c == wcols - 1'b1) begin
                  wr_c <= '0;
                  wr_r <= wr_r + 1'b1;
               end else begin
                  wr_c <= wr_c + 1'b1;
               end
               if (wr_last_hs) begin
                  wr_ready          <= 1'b0;
                  wr_done           <= 1'b1;
                  slot_valid[wslot] <= 1'b1;
                  wstate            <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate   <= R_IDLE;
         rslot    <= '0;
         rtr      <= 1'b0;
         rd_i     <= '0;
         rd_j     <= '0;
         out_n    <= '0;
         in_n     <= '0;
         rd_rows  <= '0;
         rd_cols  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
      end else begin
         case (rstate)
            R_IDLE: if (rd_accept) begin
               rslot    <= rd_slot;
               rtr      <= tr_sel;
               rd_i     <= '0;
               rd_j     <= '0;
               out_n    <= out0;
               in_n     <= in0;
               rd_rows  <= ROW_W'(out0);
               rd_cols  <= COL_W'(in0);
               rd_data  <= mem[addr_of(rd_slot, '0, '0)];
               rd_last  <= (out0 == DIM_W'(1)) && (in0 == DIM_W'(1));
               rd_valid <= 1'b1;
               rstate   <= R_STREAM;
            end
            R_STREAM: if (rd_ready) begin
               if (rd_last) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  rstate   <= R_IDLE;
               end else begin
                  rd_i    <= nxt_i;
                  rd_j    <= nxt_j;
                  rd_data <= mem[nxt_addr];
                  rd_last <= (nxt_i == out_n - 1'b1) && (nxt_j == in_n - 1'b1);
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= wr_reject | rd_reject;
   end

endmodule
`default_nettype wire

// File: doc/matrix_bank.md
Name: matrix_bank

Overview:
- Multi-slot matrix storage for the calculator. Accepts matrices as row-major element streams and replays them as element streams.
- Tracks per-slot dimensions and validity.
- Parametrised in element width, max dimensions and slot count.
- Sits between the input/generation front-end and the display and calculation engines.
- Replaces fixed-size, single-matrix packed records with a shared, handshaked store.

Parameters:
- DATA_WIDTH, 8, signed element width.
- MAX_ROWS, 5, maximum rows per matrix.
- MAX_COLS, 5, maximum columns per matrix.
- NUM_SLOTS, 8, number of stored matrices.
- Derived localparams: ROW_W=$clog2(MAX_ROWS+1), COL_W=$clog2(MAX_COLS+1), SLOT_W=$clog2(NUM_SLOTS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_start  in  1  begin writing a matrix
- wr_slot  in  SLOT_W  destination slot
- wr_rows  in  ROW_W  row count
- wr_cols  in  COL_W  column count
- wr_valid  in  1  element available
- wr_data  in  DATA_WIDTH  signed element
- wr_ready  out  1  bank accepts element
- wr_done  out  1  one-cycle pulse: matrix committed
- rd_start  in  1  begin reading a slot
- rd_slot  in  SLOT_W  source slot
- rd_transpose  in  1  column-major readout (optional feature)
- rd_rows  out  ROW_W  rows of the matrix being read (swapped when transposing)
- rd_cols  out  COL_W  cols of the matrix being read (swapped when transposing)
- rd_valid  out  1  element on rd_data
- rd_data  out  DATA_WIDTH  signed element
- rd_last  out  1  final element of the stream
- rd_ready  in  1  consumer accepts element
- slot_valid  out  NUM_SLOTS  per-slot occupied flag
- err  out  1  one-cycle pulse: rejected command

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, slot_valid all 0, both FSMs idle. Element storage is not cleared. Reset mid-stream aborts both streams and invalidates every slot.

Write FSM (W_IDLE, W_FILL):
- wr_start is sampled only in W_IDLE.
- Legal command: 1≤wr_rows≤MAX_ROWS, 1≤wr_cols≤MAX_COLS, wr_slot<NUM_SLOTS.
- On a legal command at cycle N:
  - dims and slot are latched.
  - slot_valid[wr_slot] clears at N+1.
  - wr_ready rises at N+1; state goes to W_FILL.
- On an illegal command: err pulses at N+1; state stays W_IDLE.
- In W_FILL, each cycle with wr_valid&wr_ready writes wr_data to (r,c), then increments c; at c=cols-1, c wraps to 0 and r increments.
- On the rows*cols-th handshake (cycle M):
  - wr_ready drops at M+1.
  - slot_valid[slot] sets at M+1.
  - wr_done pulses at M+1.
  - state returns to W_IDLE.
- wr_start during W_FILL: ignored, err pulses.
- wr_valid while in W_IDLE: ignored.

Read FSM (R_IDLE, R_STREAM):
- rd_start is sampled only in R_IDLE.
- Legal command: slot_valid[rd_slot]=1 and rd_slot is not the slot currently latched by the write FSM.
- On a legal command at cycle N: rd_rows/rd_cols are valid, and rd_valid rises with the first element, at N+1.
- On an illegal command: err pulses at N+1.
- rd_data and rd_last are held stable while rd_valid=1 and rd_ready=0.
- Each handshake advances to the next element in row-major order; rd_data is a registered output.
- rd_last is high on the rows*cols-th element. After its handshake, rd_valid drops next cycle and state returns to R_IDLE.
- rd_start during R_STREAM: ignored, err pulses.

Simultaneous events:
- wr_start and rd_start on the same slot in the same cycle: the write wins, the read is rejected with err.
- Several rejections in one cycle produce a single err pulse.
- Reading slot A while writing slot B is allowed, full concurrency.
- A write to a slot that is already valid overwrites it. The slot is invisible to readers until wr_done.

Optional Feature:
- Macro: MATRIX_BANK_TRANSPOSE_EN.
- Defined: when rd_transpose=1 is sampled with a legal rd_start:
  - elements stream column-major (rows of the transpose);
  - rd_rows=stored cols and rd_cols=stored rows;
  - rd_last is still on the final element.
- Undefined: rd_transpose is ignored; readout is always row-major with stored dims.

Test Plan:
- Write 2x3 {1,2,3,4,5,6} to slot 0 with wr_valid held high → wr_ready high for exactly 6 cycles; wr_done at the cycle after the 6th handshake; slot_valid=8'h01.
- Read slot 0 with rd_ready toggling 1,0,1,0 → rd_data sequence 1,2,3,4,5,6, each held through stall cycles; rd_last only with 6; rd_rows=2, rd_cols=3.
- wr_rows=6 or wr_cols=0; then rd_start on empty slot 3 → err pulses once per command; slot_valid unchanged; wr_ready stays 0.
- Concurrency:
  - Read slot 0 while writing 5x5 slot 1 with values -128..-104: both streams complete correctly.
  - wr_start and rd_start on slot 1 in the same cycle: single err pulse; write proceeds.
- Assert rst_n=0 for one cycle in mid-write at element 4 → slot_valid=0; wr_ready=0 and rd_valid=0 immediately.
- MATRIX_BANK_TRANSPOSE_EN defined, read slot 0 with rd_transpose=1 → 1,4,2,5,3,6; rd_rows=3, rd_cols=2. Same bench with the macro undefined → 1..6 row-major.
